// File: rtl/sample_serializer_if.sv
// Sample input strobe plus serial DAC outputs of the sample serializer.
interface sample_serializer_if;
  logic [15:0] sample_in;
  logic        sample_valid_in;
  logic        bclk_out;
  logic        lrclk_out;
  logic        sdata_out;
  logic        underrun_out;
  logic        overrun_out;

  modport master (
    output sample_in, sample_valid_in,
    input  bclk_out, lrclk_out, sdata_out, underrun_out, overrun_out
  );

  modport slave (
    input  sample_in, sample_valid_in,
    output bclk_out, lrclk_out, sdata_out, underrun_out, overrun_out
  );
endinterface

// File: rtl/sample_serializer.sv
// Left-justified stereo serializer for the tone generator output.
// One-entry input buffer; the mono sample goes out on both channels, MSB first.
module sample_serializer #(
  parameter int unsigned CLK_DIV = 16
) (
  input logic                clk_in,
  input logic                reset_in,
  sample_serializer_if.slave bus
);
  localparam int unsigned   DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic          bclk_q, bclk_d;
  logic          lrclk_q, lrclk_d;
  logic          sdata_q, sdata_d;
  logic          underrun_q, underrun_d;
  logic          overrun_q, overrun_d;
  logic [4:0]    bit_cnt_q, bit_cnt_d;
  logic [15:0]   frame_sample_q, frame_sample_d;
  logic [15:0]   shift_q, shift_d;
  logic [15:0]   pending_q, pending_d;
  logic          pending_valid_q, pending_valid_d;

  logic          tick;
  logic          fall;
  logic          load;
  logic [4:0]    bit_next;

  always_comb begin
    tick     = (div_cnt_q == DIV_LAST);
    fall     = tick && bclk_q;
    bit_next = bit_cnt_q + 5'd1;
    load     = fall && (bit_next == 5'd0) && pending_valid_q;

    div_cnt_d      = tick ? '0 : div_cnt_q + DW'(1);
    bclk_d         = tick ? ~bclk_q : bclk_q;
    bit_cnt_d      = fall ? bit_next : bit_cnt_q;
    lrclk_d        = fall ? bit_next[4] : lrclk_q;
    sdata_d        = sdata_q;
    shift_d        = shift_q;
    frame_sample_d = frame_sample_q;
    underrun_d     = 1'b0;

    // All data movement happens on the edge that drives bclk low, so the
    // DAC sees a stable bit at the following rising edge.
    if (fall) begin
      if (bit_next == 5'd0) begin
        if (pending_valid_q) begin
          frame_sample_d = pending_q;
          shift_d        = pending_q;
          sdata_d        = pending_q[15];
        end else begin
          shift_d    = frame_sample_q;
          sdata_d    = frame_sample_q[15];
          underrun_d = 1'b1;
        end
      end else if (bit_next == 5'd16) begin
        shift_d = frame_sample_q;
        sdata_d = frame_sample_q[15];
      end else begin
        shift_d = {shift_q[14:0], 1'b0};
        sdata_d = shift_q[14];
      end
    end

    // A new sample arriving on the frame-start edge is not an overrun: the
    // frame takes the old value and the new one refills the buffer.
    pending_d       = pending_q;
    pending_valid_d = pending_valid_q && !load;
    overrun_d       = 1'b0;
    if (bus.sample_valid_in) begin
      pending_d       = bus.sample_in;
      pending_valid_d = 1'b1;
      overrun_d       = pending_valid_q && !load;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      div_cnt_q       <= '0;
      bclk_q          <= 1'b0;
      lrclk_q         <= 1'b0;
      sdata_q         <= 1'b0;
      underrun_q      <= 1'b0;
      overrun_q       <= 1'b0;
      bit_cnt_q       <= 5'd31;
      frame_sample_q  <= '0;
      shift_q         <= '0;
      pending_q       <= '0;
      pending_valid_q <= 1'b0;
    end else begin
      div_cnt_q       <= div_cnt_d;
      bclk_q          <= bclk_d;
      lrclk_q         <= lrclk_d;
      sdata_q         <= sdata_d;
      underrun_q      <= underrun_d;
      overrun_q       <= overrun_d;
      bit_cnt_q       <= bit_cnt_d;
      frame_sample_q  <= frame_sample_d;
      shift_q         <= shift_d;
      pending_q       <= pending_d;
      pending_valid_q <= pending_valid_d;
    end
  end

  assign bus.bclk_out     = bclk_q;
  assign bus.lrclk_out    = lrclk_q;
  assign bus.sdata_out    = sdata_q;
  assign bus.underrun_out = underrun_q;
  assign bus.overrun_out  = overrun_q;
endmodule
